// File: rtl/adc_triggered_capture_pkg.sv
// Shared types and constants for the ADC triggered-capture block.
// The state encoding is visible on the status port, so the values are fixed.
package adc_triggered_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } capture_state_t;

    // The 8-bit capture sample is taken from the 12-bit XADC result field.
    localparam int SAMPLE_MSB = 11;
    localparam int SAMPLE_LSB = 4;
    localparam int SAMPLE_W   = SAMPLE_MSB - SAMPLE_LSB + 1;

endpackage

// File: rtl/adc_level_crossing_detect.sv
// Combinational threshold-crossing detector: compares the previous and the
// current sample against the threshold, unsigned, in the selected direction.
module adc_level_crossing_detect
    import adc_triggered_capture_pkg::*;
(
    input  logic [SAMPLE_W-1:0] prev,
    input  logic [SAMPLE_W-1:0] cur,
    input  logic [SAMPLE_W-1:0] thr,
    input  logic                edge_rising,
    input  logic                prev_valid,
    output logic                hit
);

    always_comb begin
        hit = 1'b0;
        if (prev_valid) begin
            if (edge_rising) begin
                hit = (prev < thr) && (cur >= thr);
            end else begin
                hit = (prev >= thr) && (cur < thr);
            end
        end
    end

endmodule

// File: rtl/adc_triggered_capture.sv
// XADC-driven capture engine: paces conversions, writes samples into a circular
// buffer, and freezes the buffer around a level-crossing or software trigger.
module adc_triggered_capture
    import adc_triggered_capture_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_arm,
    input  logic                 cfg_sw_trigger,
    input  logic                 cfg_edge_rising,
    input  logic [7:0]           cfg_threshold,
    input  logic [ADDR_BITS-1:0] cfg_pretrig,
    input  logic                 adc_drdy,
    input  logic [15:0]          adc_data,
    output logic                 adc_trigger,
    output logic [ADDR_BITS-1:0] bram_waddr,
    output logic [7:0]           bram_wdata,
    output logic                 bram_wen,
    output logic [ADDR_BITS-1:0] trig_addr,
    output logic [2:0]           state,
    output logic                 done
);

    // All-ones is DEPTH-1, the largest pretrigger count; the port width already
    // caps cfg_pretrig there, so no further clamp is needed.
    localparam logic [ADDR_BITS-1:0] MAX_P = '1;
    localparam logic [ADDR_BITS-1:0] ONE   = ADDR_BITS'(1);

    capture_state_t state_q, state_d;

    logic                 arm_q;
    logic                 pending;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] pre_cnt;
    logic [ADDR_BITS-1:0] post_cnt;
    logic [ADDR_BITS-1:0] p_reg;
    logic [7:0]           prev;
    logic                 prev_valid;
    logic                 trig_wait;

    logic [7:0]           sample;
    logic                 hit;
    logic                 active;
    logic                 arm_edge;
    logic                 accept;
    logic                 trig_now;
    logic [ADDR_BITS-1:0] pre_inc;
    logic [ADDR_BITS-1:0] post_inc;
    logic [ADDR_BITS-1:0] post_target;
    logic                 unused_adc_bits;

    assign unused_adc_bits = ^{adc_data[15:SAMPLE_MSB+1], adc_data[SAMPLE_LSB-1:0]};

    adc_level_crossing_detect u_detect (
        .prev        (prev),
        .cur         (sample),
        .thr         (cfg_threshold),
        .edge_rising (cfg_edge_rising),
        .prev_valid  (prev_valid),
        .hit         (hit)
    );

    always_comb begin
        sample      = adc_data[SAMPLE_MSB:SAMPLE_LSB];
        active      = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
        arm_edge    = cfg_arm && !arm_q;
        accept      = active && cfg_arm && adc_drdy;
        adc_trigger = active && cfg_arm && !pending && !adc_drdy;
        pre_inc     = pre_cnt + ONE;
        post_inc    = post_cnt + ONE;
        post_target = MAX_P - p_reg;
        // A software trigger with no sample this cycle names the next sample written.
        trig_now    = (state_q == ST_ARMED) && cfg_arm && ((accept && hit) || cfg_sw_trigger);
        state       = state_q;
        done        = (state_q == ST_DONE);
    end

    always_comb begin
        state_d = state_q;
        if (!cfg_arm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_edge) state_d = (cfg_pretrig == '0) ? ST_ARMED : ST_PRE;
                end
                ST_PRE: begin
                    if (accept && (pre_inc == p_reg)) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_now) state_d = (accept && (p_reg == MAX_P)) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (accept && ((trig_wait && (p_reg == MAX_P)) ||
                                   (!trig_wait && (post_inc == post_target)))) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // arm_q resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b1;
            pending    <= 1'b0;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            p_reg      <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            trig_wait  <= 1'b0;
            trig_addr  <= '0;
            bram_wen   <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
        end else begin
            state_q  <= state_d;
            arm_q    <= cfg_arm;
            bram_wen <= accept;

            if (adc_drdy) begin
                pending <= 1'b0;
            end else if (adc_trigger) begin
                pending <= 1'b1;
            end

            if (arm_edge && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
                wr_ptr     <= '0;
                pre_cnt    <= '0;
                post_cnt   <= '0;
                prev_valid <= 1'b0;
                trig_wait  <= 1'b0;
                p_reg      <= cfg_pretrig;
            end else if (accept) begin
                bram_waddr <= wr_ptr;
                bram_wdata <= sample;
                wr_ptr     <= wr_ptr + ONE;
                prev       <= sample;
                prev_valid <= 1'b1;
                if (state_q == ST_PRE) pre_cnt <= pre_inc;
                if (state_q == ST_POST) begin
                    if (trig_wait) begin
                        trig_wait <= 1'b0;
                    end else begin
                        post_cnt <= post_inc;
                    end
                end
            end

            if (trig_now) begin
                trig_addr <= wr_ptr;
                if (!accept) trig_wait <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_triggered_capture.sv
// Directed bench for adc_triggered_capture with a sample-index model of the
// expected buffer writes and a responder that stands in for the XADC.
module tb_adc_triggered_capture;

    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_arm = 1'b0;
    logic          cfg_sw_trigger = 1'b0;
    logic          cfg_edge_rising = 1'b1;
    logic [7:0]    cfg_threshold = 8'h00;
    logic [AB-1:0] cfg_pretrig = '0;
    logic          adc_drdy = 1'b0;
    logic [15:0]   adc_data = 16'h0000;
    logic          adc_trigger;
    logic [AB-1:0] bram_waddr;
    logic [7:0]    bram_wdata;
    logic          bram_wen;
    logic [AB-1:0] trig_addr;
    logic [2:0]    state;
    logic          done;

    adc_triggered_capture #(.ADDR_BITS(AB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_arm         (cfg_arm),
        .cfg_sw_trigger  (cfg_sw_trigger),
        .cfg_edge_rising (cfg_edge_rising),
        .cfg_threshold   (cfg_threshold),
        .cfg_pretrig     (cfg_pretrig),
        .adc_drdy        (adc_drdy),
        .adc_data        (adc_data),
        .adc_trigger     (adc_trigger),
        .bram_waddr      (bram_waddr),
        .bram_wdata      (bram_wdata),
        .bram_wen        (bram_wen),
        .trig_addr       (trig_addr),
        .state           (state),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // XADC stand-in: a conversion request is answered one cycle later from the feed queue.
    logic [7:0] feed[$];
    bit         owed = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (adc_trigger) owed = 1'b1;
            @(posedge clk);
            #1;
            adc_drdy = 1'b0;
            if (owed && rst_n && feed.size() > 0) begin
                adc_data = {4'hA, feed.pop_front(), 4'h5};
                adc_drdy = 1'b1;
                owed     = 1'b0;
            end
        end
    end

    // Model: the k-th write after arming holds sample k at address k mod DEPTH.
    logic [7:0] smp[$];
    bit         swf[$];
    bit         sw_lat;
    int         wr_k;
    bit         m_trig;
    int         m_end;
    int         m_p;
    bit         m_rise;
    logic [7:0] m_thr;
    logic [7:0] mem [DEPTH];
    int         last_waddr;

    function automatic bit crossing(input logic [7:0] a, input logic [7:0] b);
        return m_rise ? (a < m_thr && b >= m_thr) : (a >= m_thr && b < m_thr);
    endfunction

    task automatic model_reset(input int p, input bit rise, input logic [7:0] thr);
        smp.delete();
        swf.delete();
        sw_lat     = 1'b0;
        wr_k       = 0;
        m_trig     = 1'b0;
        m_end      = 0;
        m_p        = p;
        m_rise     = rise;
        m_thr      = thr;
        last_waddr = -1;
        foreach (mem[i]) mem[i] = 8'h00;
    endtask

    initial begin
        int exp_state;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (adc_drdy) check("trigger_with_drdy", adc_trigger, 0);
                if (bram_wen) begin
                    if (wr_k >= smp.size() || (m_trig && wr_k > m_end)) begin
                        check("write_allowed", bram_wen, 0);
                    end else begin
                        check("waddr", bram_waddr, wr_k % DEPTH);
                        check("wdata", bram_wdata, smp[wr_k]);
                        mem[bram_waddr] = bram_wdata;
                        last_waddr      = bram_waddr;
                        if (!m_trig && wr_k >= m_p &&
                            ((wr_k >= 1 && crossing(smp[wr_k-1], smp[wr_k])) || swf[wr_k])) begin
                            m_trig = 1'b1;
                            m_end  = wr_k + DEPTH - 1 - m_p;
                        end
                        if (m_trig) exp_state = (wr_k == m_end) ? 4 : 3;
                        else        exp_state = (wr_k + 1 < m_p) ? 1 : 2;
                        check("state_after_write", state, exp_state);
                        check("done_after_write", done, (exp_state == 4) ? 1 : 0);
                        wr_k++;
                    end
                end
                if (adc_drdy) begin
                    smp.push_back(adc_data[11:4]);
                    swf.push_back(sw_lat || cfg_sw_trigger);
                    sw_lat = 1'b0;
                end else if (cfg_sw_trigger) begin
                    sw_lat = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic arm(input int p, input bit rise, input logic [7:0] thr);
        cfg_arm = 1'b0;
        feed.delete();
        tick(2);
        model_reset(p, rise, thr);
        cfg_pretrig     = AB'(p);
        cfg_edge_rising = rise;
        cfg_threshold   = thr;
        cfg_arm         = 1'b1;
        tick(1);
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int c = 0;
        while (wr_k < n && c < budget) begin
            tick(1);
            c++;
        end
        check(name, wr_k, n);
    endtask

    task automatic wait_drdy_at(input int idx, input string name);
        int c = 0;
        while (!(adc_drdy && smp.size() == idx) && c < 200) begin
            tick(1);
            c++;
        end
        check(name, smp.size(), idx);
    endtask

    initial begin
        int t5_idx;

        // Reset values, applied asynchronously before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_trigger", adc_trigger, 0);
        check("rst_wen", bram_wen, 0);
        check("rst_done", done, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_waddr", bram_waddr, 0);
        check("rst_wdata", bram_wdata, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("idle_after_rst", state, 0);

        // Rising trigger, P=4: trigger on the seventh sample.
        arm(4, 1'b1, 8'h80);
        check("t1_pre_entry", state, 1);
        repeat (6) feed.push_back(8'h10);
        feed.push_back(8'h90);
        for (int i = 0; i < 11; i++) feed.push_back(8'(8'h20 + i));
        wait_writes(18, 300, "t1_writes");
        tick(2);
        check("t1_trig_addr", trig_addr, 6);
        check("t1_state", state, 4);
        check("t1_done", done, 1);
        check("t1_oldest", mem[2], 8'h10);
        check("t1_newest", mem[1], 8'h2A);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t1_done_no_conv", adc_trigger, 0);
        end

        // Falling trigger: a rising step must not fire.
        arm(0, 1'b0, 8'h40);
        check("t2_p0_armed", state, 2);
        feed.push_back(8'h30);
        feed.push_back(8'h50);
        wait_writes(2, 50, "t2a_writes");
        tick(3);
        check("t2a_no_trigger", state, 2);

        arm(0, 1'b0, 8'h40);
        feed.push_back(8'h50);
        feed.push_back(8'h30);
        repeat (15) feed.push_back(8'h70);
        wait_writes(17, 300, "t2b_writes");
        tick(2);
        check("t2b_trig_addr", trig_addr, 1);
        check("t2b_done", done, 1);

        // Maximum pretrigger: a crossing inside PRE is ignored, trigger is the last write.
        arm(15, 1'b1, 8'h80);
        for (int i = 0; i < 15; i++) feed.push_back((i == 5) ? 8'h90 : 8'h10);
        feed.push_back(8'h90);
        wait_writes(16, 300, "t3_writes");
        tick(2);
        check("t3_trig_addr", trig_addr, 15);
        check("t3_state", state, 4);

        // Long ARMED wrap, then a software trigger with no sample in flight.
        arm(2, 1'b1, 8'h80);
        repeat (40) feed.push_back(8'h10);
        wait_writes(40, 600, "t4_writes");
        tick(2);
        check("t4_still_armed", state, 2);
        check("t4_last_waddr", bram_waddr, 7);
        cfg_sw_trigger = 1'b1;
        tick(1);
        cfg_sw_trigger = 1'b0;
        check("t4_sw_post", state, 3);
        repeat (14) feed.push_back(8'h10);
        wait_writes(54, 300, "t4_post_writes");
        tick(2);
        check("t4_trig_addr", trig_addr, 8);
        check("t4_done", done, 1);

        // Software trigger coincident with a sample: that sample is the trigger.
        arm(0, 1'b1, 8'h80);
        repeat (24) feed.push_back(8'h10);
        wait_drdy_at(3, "t5_reach_sample3");
        t5_idx = smp.size();
        cfg_sw_trigger = 1'b1;
        tick(1);
        cfg_sw_trigger = 1'b0;
        wait_writes(t5_idx + 16, 300, "t5_writes");
        tick(2);
        check("t5_trig_addr", trig_addr, t5_idx % DEPTH);
        check("t5_done", done, 1);

        // Disarm in POST while a sample arrives, then re-arm from address 0.
        arm(0, 1'b1, 8'h80);
        feed.push_back(8'h10);
        feed.push_back(8'h90);
        for (int i = 0; i < 4; i++) feed.push_back(8'(8'h20 + i));
        wait_drdy_at(5, "t6_reach_sample5");
        cfg_arm = 1'b0;
        tick(1);
        check("t6_idle", state, 0);
        for (int i = 0; i < 6; i++) begin
            check("t6_no_conv", adc_trigger, 0);
            check("t6_no_write", bram_wen, 0);
            tick(1);
        end
        check("t6_write_count", wr_k, 5);
        arm(0, 1'b1, 8'h80);
        feed.push_back(8'h11);
        wait_writes(1, 50, "t6_rearm_write");
        check("t6_rearm_addr", last_waddr, 0);

        // Asynchronous reset mid-POST with the arm level held high.
        arm(0, 1'b1, 8'h80);
        feed.push_back(8'h10);
        feed.push_back(8'h90);
        repeat (6) feed.push_back(8'h30);
        wait_writes(4, 100, "t7_writes");
        check("t7_in_post", state, 3);
        #1 rst_n = 1'b0;
        #1;
        check("t7_rst_state", state, 0);
        check("t7_rst_trigger", adc_trigger, 0);
        check("t7_rst_wen", bram_wen, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_trig_addr", trig_addr, 0);
        check("t7_rst_waddr", bram_waddr, 0);
        check("t7_rst_wdata", bram_wdata, 0);
        tick(2);
        feed.delete();
        owed = 1'b0;
        model_reset(0, 1'b1, 8'h80);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("t7_stay_idle", state, 0);
            check("t7_no_conv", adc_trigger, 0);
        end
        cfg_arm = 1'b0;
        tick(1);
        cfg_arm = 1'b1;
        tick(1);
        check("t7_rearm_toggle", state, 2);
        cfg_arm = 1'b0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
